// File: rtl/seq_pkg.sv
// Shared types and constants for the teaching-CPU fetch/decode/execute sequencer.
package seq_pkg;

   localparam int AW = 12;
   localparam int IW = 16;
   localparam int CW = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      HALT   = 3'd4
   } state_e;

   localparam logic [3:0] OP_HALT = 4'hF;
   localparam logic [3:0] OP_JMP  = 4'hE;
   localparam logic [3:0] OP_BZ   = 4'hD;

   // How the next pc is formed: pc+1, absolute operand, or pc+operand (taken BZ).
   typedef enum logic [1:0] {
      NPC_INC = 2'd0,
      NPC_ABS = 2'd1,
      NPC_REL = 2'd2
   } npc_kind_e;

endpackage

// File: rtl/next_pc_unit.sv
// Combinational next-pc selection; all arithmetic wraps at 2^AW.
module next_pc_unit
   import seq_pkg::*;
#(
   parameter int AW = seq_pkg::AW
) (
   input  logic [AW-1:0] pc,
   input  logic [AW-1:0] operand,
   input  npc_kind_e     kind,
   output logic [AW-1:0] next_pc
);

   always_comb begin
      next_pc = pc + AW'(1);
      case (kind)
         NPC_INC: next_pc = pc + AW'(1);
         NPC_ABS: next_pc = operand;
         // A two's-complement offset added modulo 2^AW is plain unsigned addition.
         NPC_REL: next_pc = pc + operand;
         default: next_pc = pc + AW'(1);
      endcase
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/execute controller: owns pc and ir, resolves JMP/BZ/HALT,
// and hands every other instruction to the datapath via a one-cycle ir_valid pulse.
module fetch_sequencer
   import seq_pkg::*;
#(
   parameter int AW = seq_pkg::AW,
   parameter int IW = seq_pkg::IW,
   parameter int CW = seq_pkg::CW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stop,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [IW-1:0] imem_rdata,
   output logic [IW-1:0] ir,
   output logic          ir_valid,
   input  logic          exec_done,
   input  logic          br_cond,
   output logic [AW-1:0] pc,
   output logic          halted,
   output logic [CW-1:0] retired,
   output logic [2:0]    state_dbg
);

   // Handshake: imem_req stays high with imem_addr stable from FETCH entry until the
   // cycle imem_ack is seen; the word is captured on that edge and req drops next cycle.

   state_e        state, state_next;
   logic          stop_pend;
   logic          pc_en;
   logic          retire;
   npc_kind_e     npc_kind;
   logic [AW-1:0] next_pc;
   logic [3:0]    opcode;
   logic [AW-1:0] operand;

   assign opcode  = ir[IW-1:IW-4];
   assign operand = ir[AW-1:0];

   next_pc_unit #(.AW(AW)) u_next_pc (
      .pc      (pc),
      .operand (operand),
      .kind    (npc_kind),
      .next_pc (next_pc)
   );

   always_comb begin
      npc_kind = NPC_INC;
      if (state == DECODE && opcode == OP_JMP)
         npc_kind = NPC_ABS;
      else if (state == DECODE && opcode == OP_BZ && br_cond)
         npc_kind = NPC_REL;
   end

   always_comb begin
      state_next = state;
      pc_en      = 1'b0;
      retire     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = FETCH;
         end
         FETCH: begin
            if (imem_ack) state_next = DECODE;
         end
         DECODE: begin
            case (opcode)
               OP_HALT: begin
                  retire     = 1'b1;
                  state_next = HALT;
               end
               OP_JMP, OP_BZ: begin
                  pc_en      = 1'b1;
                  retire     = 1'b1;
                  state_next = stop_pend ? HALT : FETCH;
               end
               default: state_next = EXEC;
            endcase
         end
         EXEC: begin
            if (exec_done) begin
               pc_en      = 1'b1;
               retire     = 1'b1;
               state_next = stop_pend ? HALT : FETCH;
            end
         end
         HALT: begin
            if (start) begin
               pc_en      = 1'b1;
               state_next = FETCH;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pc        <= '0;
         ir        <= '0;
         ir_valid  <= 1'b0;
         retired   <= '0;
         stop_pend <= 1'b0;
      end else begin
         state    <= state_next;
         ir_valid <= (state == DECODE) && (state_next == EXEC);
         if (pc_en)
            pc <= next_pc;
         if (state == FETCH && imem_ack)
            ir <= imem_rdata;
         if (retire)
            retired <= retired + CW'(1);
         // Entering HALT or resuming from it services the request; a stop raised in
         // that same cycle is deliberately dropped.
         if ((state_next == HALT && state != HALT) || (state == HALT && start))
            stop_pend <= 1'b0;
         else if (stop)
            stop_pend <= 1'b1;
      end
   end

   assign imem_req  = (state == FETCH);
   assign imem_addr = pc;
   assign halted    = (state == HALT);
   assign state_dbg = state;

endmodule
